// File: rtl/pconv_feeder_c1_if.sv
// Beat stream between the layer-1 feeder and the pointwise conv unit.
// The conv_vld/dout_rdy pair is the handshake; everything else rides along with valid.
interface pconv_feeder_c1_if #(
  parameter int N = 16
);
  logic         conv_vld;
  logic         dout_rdy;
  logic [N-1:0] conv_din;
  logic [N-1:0] conv_weight;
  logic [31:0]  conv_bias;
  logic [4:0]   conv_shift;
  logic         conv_last;

  modport master (
    output conv_vld, conv_din, conv_weight, conv_bias, conv_shift, conv_last,
    input  dout_rdy
  );

  modport slave (
    input  conv_vld, conv_din, conv_weight, conv_bias, conv_shift, conv_last,
    output dout_rdy
  );
endinterface

// File: rtl/pconv_feeder_c1.sv
// Layer-1 pointwise-conv feeder: walks channels x pixels, reads the feature map and
// parameter store, and presents aligned beats with a valid/ready handshake.
module pconv_feeder_c1 #(
  parameter int N           = 16,
  parameter int IMG_SIZE    = 28,
  parameter int OUT_CHANNEL = 4,
  parameter int PIX_AW      = 10,
  parameter int CH_AW       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 fm_rd_en,
  output logic [PIX_AW-1:0]    fm_addr,
  input  logic [N-1:0]         fm_data,
  output logic                 par_rd_en,
  output logic [CH_AW-1:0]     par_addr,
  input  logic [N-1:0]         par_weight,
  input  logic [31:0]          par_bias,
  input  logic [4:0]           par_shift,
  pconv_feeder_c1_if.master    conv,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PIX_AW-1:0] PIX_LAST = PIX_AW'(IMG_SIZE * IMG_SIZE - 1);
  localparam logic [CH_AW-1:0]  CH_LAST  = CH_AW'(OUT_CHANNEL - 1);

  logic [1:0]        state_q, state_d;
  logic [PIX_AW-1:0] pix_q, pix_d;
  logic [CH_AW-1:0]  ch_q, ch_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              issue;
  logic              pix_wrap;
  logic              final_read;

  // A new read may issue whenever the output slot is empty or being drained this cycle.
  assign issue      = (state_q == S_RUN) && (!vld_q || conv.dout_rdy);
  assign pix_wrap   = (pix_q == PIX_LAST);
  assign final_read = issue && pix_wrap && (ch_q == CH_LAST);

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pix_d   = '0;
          ch_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (final_read) begin
          state_d = S_DRAIN;
          pix_d   = '0;
          ch_d    = '0;
        end else if (issue && pix_wrap) begin
          state_d = S_RUN;
          pix_d   = '0;
          ch_d    = ch_q + CH_AW'(1'b1);
        end else if (issue) begin
          state_d = S_RUN;
          pix_d   = pix_q + PIX_AW'(1'b1);
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (vld_q && conv.dout_rdy) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Valid and last only change on an issue or a completed transfer, so a stalled beat holds.
  always_comb begin
    if (issue) begin
      vld_d  = 1'b1;
      last_d = pix_wrap;
    end else if (conv.dout_rdy) begin
      vld_d  = 1'b0;
      last_d = last_q;
    end else begin
      vld_d  = vld_q;
      last_d = last_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      ch_q    <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign fm_rd_en  = issue;
  assign par_rd_en = issue;
  assign fm_addr   = pix_q;
  assign par_addr  = ch_q;

  // Memories hold their outputs while the strobe is low, so the pass-through stays aligned.
  assign conv.conv_vld    = vld_q;
  assign conv.conv_din    = vld_q ? fm_data    : '0;
  assign conv.conv_weight = vld_q ? par_weight : '0;
  assign conv.conv_bias   = vld_q ? par_bias   : 32'd0;
  assign conv.conv_shift  = vld_q ? par_shift  : 5'd0;
  assign conv.conv_last   = vld_q & last_q;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_pconv_feeder_c1.sv
// Directed bench for pconv_feeder_c1 with IMG_SIZE=4, OUT_CHANNEL=2 and registered memory models.
module tb_pconv_feeder_c1;
  localparam int N     = 16;
  localparam int IMG   = 4;
  localparam int OCH   = 2;
  localparam int PAW   = 4;
  localparam int CAW   = 1;
  localparam int PPC   = IMG * IMG;
  localparam int BEATS = OCH * PPC;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           fm_rd_en, par_rd_en;
  logic [PAW-1:0] fm_addr;
  logic [CAW-1:0] par_addr;
  logic [N-1:0]   fm_data = '0;
  logic [N-1:0]   par_weight = '0;
  logic [31:0]    par_bias = 32'd0;
  logic [4:0]     par_shift = 5'd0;
  logic           busy, done;

  int checks = 0;
  int errors = 0;

  pconv_feeder_c1_if #(.N(N)) conv_if ();

  pconv_feeder_c1 #(
    .N(N), .IMG_SIZE(IMG), .OUT_CHANNEL(OCH), .PIX_AW(PAW), .CH_AW(CAW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .fm_rd_en(fm_rd_en), .fm_addr(fm_addr), .fm_data(fm_data),
    .par_rd_en(par_rd_en), .par_addr(par_addr),
    .par_weight(par_weight), .par_bias(par_bias), .par_shift(par_shift),
    .conv(conv_if), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory models: one-cycle read latency, output held while the strobe is low.
  always @(posedge clk) begin
    if (fm_rd_en === 1'b1) fm_data <= N'(fm_addr) + 16'd1;
    if (par_rd_en === 1'b1) begin
      par_weight <= N'(par_addr) + 16'd10;
      par_bias   <= 32'(par_addr) * 32'd1000 + 32'd7;
      par_shift  <= 5'(par_addr) + 5'd3;
    end
  end

  int           nbeats, done_cyc, first_vld_cyc, done_pulses, freeze_viol, vld_after_done;
  logic         rst_vld;
  bit           timed_out;
  logic [N-1:0] b_din   [64];
  logic [N-1:0] b_w     [64];
  logic [31:0]  b_bias  [64];
  logic [4:0]   b_shift [64];
  logic         b_last  [64];
  int           b_cyc   [64];

  // Drives one pass and records what the DUT emitted; the test tasks judge the record.
  task automatic run_pass(input int stall_a, input int stall_b, input int busy_beat,
                          input bit start_on_done, input int rst_beat);
    int cyc, cnt_a, cnt_b;
    bit stalling;
    logic [N-1:0] h_din, h_w;
    logic h_last;
    nbeats = 0; done_cyc = -1; first_vld_cyc = -1; done_pulses = 0;
    freeze_viol = 0; vld_after_done = 0; rst_vld = 1'bx; timed_out = 1'b1;
    cnt_a = 0; cnt_b = 0; stalling = 1'b0; h_din = '0; h_w = '0; h_last = 1'b0;
    conv_if.dout_rdy = 1'b1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    while (cyc < 300) begin
      start = 1'b0;
      if (rst_beat > 0 && nbeats == rst_beat) begin
        #2 rst = 1'b1;
        #1 rst_vld = conv_if.conv_vld;
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) begin
          @(posedge clk); #1;
          if (done === 1'b1) done_pulses++;
          if (conv_if.conv_vld === 1'b1) vld_after_done++;
        end
        timed_out = 1'b0;
        break;
      end
      if (conv_if.conv_vld === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (done === 1'b1) begin
        done_pulses++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          if (start_on_done) start = 1'b1;
        end
      end
      if (done_cyc >= 0 && cyc > done_cyc && conv_if.conv_vld === 1'b1) vld_after_done++;
      if (done_cyc >= 0 && cyc >= done_cyc + 6) begin
        timed_out = 1'b0;
        break;
      end
      conv_if.dout_rdy = 1'b1;
      if (conv_if.conv_vld === 1'b1 &&
          ((nbeats + 1 == stall_a && cnt_a < 3) || (nbeats + 1 == stall_b && cnt_b < 3))) begin
        conv_if.dout_rdy = 1'b0;
        if (nbeats + 1 == stall_a) cnt_a++;
        else cnt_b++;
        if (!stalling) begin
          h_din = conv_if.conv_din; h_w = conv_if.conv_weight; h_last = conv_if.conv_last;
          stalling = 1'b1;
        end else if (conv_if.conv_din !== h_din || conv_if.conv_weight !== h_w ||
                     conv_if.conv_last !== h_last) begin
          freeze_viol++;
        end
      end else if (stalling) begin
        if (conv_if.conv_din !== h_din || conv_if.conv_weight !== h_w ||
            conv_if.conv_last !== h_last || conv_if.conv_vld !== 1'b1) freeze_viol++;
        stalling = 1'b0;
      end
      if (conv_if.conv_vld === 1'b1 && conv_if.dout_rdy === 1'b1 && nbeats < 64) begin
        b_din[nbeats]   = conv_if.conv_din;
        b_w[nbeats]     = conv_if.conv_weight;
        b_bias[nbeats]  = conv_if.conv_bias;
        b_shift[nbeats] = conv_if.conv_shift;
        b_last[nbeats]  = conv_if.conv_last;
        b_cyc[nbeats]   = cyc;
        nbeats++;
        if (nbeats == busy_beat) start = 1'b1;
      end
      @(posedge clk); #1; cyc++;
    end
    conv_if.dout_rdy = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    int rd_seen, vld_seen;
    conv_if.dout_rdy = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (conv_if.conv_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", conv_if.conv_vld); end
    checks++; if (conv_if.conv_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", conv_if.conv_last); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    checks++; if (fm_rd_en !== 1'b0 || par_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b%b expected 00", fm_rd_en, par_rd_en); end
    checks++; if (fm_addr !== '0 || par_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d/%0d expected 0/0", fm_addr, par_addr); end
    checks++;
    if ({conv_if.conv_din, conv_if.conv_weight, conv_if.conv_bias, conv_if.conv_shift} !== '0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h/%h expected all 0", conv_if.conv_din,
                         conv_if.conv_weight, conv_if.conv_bias, conv_if.conv_shift);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_seen = 0; vld_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (fm_rd_en !== 1'b0 || par_rd_en !== 1'b0) rd_seen++;
      if (conv_if.conv_vld !== 1'b0 || busy !== 1'b0) vld_seen++;
    end
    checks++; if (rd_seen != 0) begin errors++; $display("FAIL idle_reads: got %0d expected 0", rd_seen); end
    checks++; if (vld_seen != 0) begin errors++; $display("FAIL idle_vld: got %0d expected 0", vld_seen); end
  endtask

  task automatic test_full_pass();
    run_pass(0, 0, 0, 1'b0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL full_timeout: got no done expected done"); end
    checks++; if (nbeats != BEATS) begin errors++; $display("FAIL full_count: got %0d expected %0d", nbeats, BEATS); end
    checks++; if (first_vld_cyc != 2) begin errors++; $display("FAIL full_latency: got %0d expected 2", first_vld_cyc); end
    checks++; if (done_cyc != BEATS + 2) begin errors++; $display("FAIL full_done_cycle: got %0d expected %0d", done_cyc, BEATS + 2); end
    checks++; if (done_pulses != 1) begin errors++; $display("FAIL full_done_pulses: got %0d expected 1", done_pulses); end
    for (int i = 0; i < BEATS && i < nbeats; i++) begin
      checks++;
      if (b_din[i] !== N'(i % PPC + 1) || b_w[i] !== N'(i / PPC + 10) ||
          b_bias[i] !== 32'((i / PPC) * 1000 + 7) || b_shift[i] !== 5'(i / PPC + 3) ||
          b_last[i] !== ((i % PPC) == PPC - 1)) begin
        errors++;
        $display("FAIL full_beat%0d: got din=%0d w=%0d b=%0d s=%0d last=%b expected din=%0d w=%0d b=%0d s=%0d last=%b",
                 i + 1, b_din[i], b_w[i], b_bias[i], b_shift[i], b_last[i], i % PPC + 1, i / PPC + 10,
                 (i / PPC) * 1000 + 7, i / PPC + 3, (i % PPC) == PPC - 1);
      end
      checks++;
      if (b_cyc[i] != i + 2) begin errors++; $display("FAIL full_gap%0d: got cycle %0d expected %0d", i + 1, b_cyc[i], i + 2); end
    end
    checks++;
    if (b_din[16] !== 16'd1 || b_w[16] !== 16'd11) begin
      errors++; $display("FAIL full_beat17: got %0d/%0d expected 1/11", b_din[16], b_w[16]);
    end
    checks++;
    if (conv_if.conv_din !== '0 || conv_if.conv_weight !== '0 || conv_if.conv_last !== 1'b0) begin
      errors++; $display("FAIL idle_gating: got %0d/%0d/%b expected 0/0/0", conv_if.conv_din, conv_if.conv_weight, conv_if.conv_last);
    end
  endtask

  task automatic test_backpressure();
    run_pass(5, 16, 0, 1'b0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: got no done expected done"); end
    checks++; if (nbeats != BEATS) begin errors++; $display("FAIL bp_count: got %0d expected %0d", nbeats, BEATS); end
    checks++; if (freeze_viol != 0) begin errors++; $display("FAIL bp_frozen: got %0d changes expected 0", freeze_viol); end
    checks++; if (done_cyc != BEATS + 2 + 6) begin errors++; $display("FAIL bp_done_cycle: got %0d expected %0d", done_cyc, BEATS + 8); end
    for (int i = 0; i < BEATS && i < nbeats; i++) begin
      checks++;
      if (b_din[i] !== N'(i % PPC + 1) || b_w[i] !== N'(i / PPC + 10) ||
          b_last[i] !== ((i % PPC) == PPC - 1)) begin
        errors++;
        $display("FAIL bp_beat%0d: got din=%0d w=%0d last=%b expected din=%0d w=%0d last=%b",
                 i + 1, b_din[i], b_w[i], b_last[i], i % PPC + 1, i / PPC + 10, (i % PPC) == PPC - 1);
      end
    end
  endtask

  task automatic test_start_while_busy();
    run_pass(0, 0, 10, 1'b1, 0);
    checks++; if (nbeats != BEATS) begin errors++; $display("FAIL busy_count: got %0d expected %0d", nbeats, BEATS); end
    checks++; if (done_cyc != BEATS + 2) begin errors++; $display("FAIL busy_done_cycle: got %0d expected %0d", done_cyc, BEATS + 2); end
    checks++; if (done_pulses != 1) begin errors++; $display("FAIL busy_done_pulses: got %0d expected 1", done_pulses); end
    checks++; if (vld_after_done != 0) begin errors++; $display("FAIL busy_restart: got %0d beats expected 0", vld_after_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_pass();
    run_pass(0, 0, 0, 1'b0, 20);
    checks++; if (rst_vld !== 1'b0) begin errors++; $display("FAIL midrst_vld: got %b expected 0", rst_vld); end
    checks++; if (nbeats != 20) begin errors++; $display("FAIL midrst_count: got %0d expected 20", nbeats); end
    checks++; if (done_pulses != 0 || vld_after_done != 0) begin
      errors++; $display("FAIL midrst_quiet: got done=%0d vld=%0d expected 0/0", done_pulses, vld_after_done);
    end
    run_pass(0, 0, 0, 1'b0, 0);
    checks++; if (b_din[0] !== 16'd1 || b_w[0] !== 16'd10) begin
      errors++; $display("FAIL midrst_restart: got %0d/%0d expected 1/10", b_din[0], b_w[0]);
    end
    checks++; if (nbeats != BEATS) begin errors++; $display("FAIL midrst_recount: got %0d expected %0d", nbeats, BEATS); end
  endtask

  initial begin
    conv_if.dout_rdy = 1'b1;
    test_reset();
    test_full_pass();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_pass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
